// File: rtl/cardinal_nic_chan.sv
// Cardinal NIC channel: one-packet output and input buffers between the
// processor register port and the ring router, with VC-polarity gated send.
module cardinal_nic_chan #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam logic [0:ADDR_WIDTH-1] A_IN_DATA  = ADDR_WIDTH'(0);
    localparam logic [0:ADDR_WIDTH-1] A_IN_STAT  = ADDR_WIDTH'(1);
    localparam logic [0:ADDR_WIDTH-1] A_OUT_DATA = ADDR_WIDTH'(2);
    localparam logic [0:ADDR_WIDTH-1] A_OUT_STAT = ADDR_WIDTH'(3);

    logic [0:DATA_WIDTH-1] in_buf, out_buf;
    logic                  in_full, out_full;
    logic                  rd_en, wr_en, rd_clear, rx_take, tx_load;

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_en    = nicEn & nicWrEn;
    assign rd_clear = rd_en & (addr == A_IN_DATA) & in_full;
    assign rx_take  = net_si & ~in_full;
    assign tx_load  = wr_en & (addr == A_OUT_DATA) & ~out_full;

    assign net_ri = ~in_full;
    // out_buf[0] is the packet's VC bit; it must match the ring's current polarity.
    assign net_so = out_full & net_ro & (out_buf[0] == net_polarity);
    assign net_do = out_buf;

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                A_IN_DATA:  d_out = in_buf;
                A_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                A_OUT_DATA: d_out = out_buf;
                A_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:    d_out = '0;
            endcase
        end
    end

    // Input channel: read-clear and receive are mutually exclusive since
    // net_ri is low whenever in_full is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (rd_clear) begin
            in_full <= 1'b0;
        end else if (rx_take) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end
    end

    // Output channel: a write landing on the send cycle sees out_full=1 and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (net_so) begin
            out_full <= 1'b0;
        end else if (tx_load) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cardinal_nic_chan.sv
// Directed bench for cardinal_nic_chan: queue-based channel model compared
// every negedge, plus hand-computed literal checks on key cycles.
module tb_cardinal_nic_chan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0, nicWrEn = 1'b0;
    logic        net_si = 1'b0, net_ro = 1'b0, net_polarity = 1'b0;
    logic        net_ri, net_so;
    logic [63:0] net_di = '0;
    logic [63:0] net_do;

    int checks = 0;
    int errors = 0;

    cardinal_nic_chan #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue holding at most one packet; the last
    // packet written/received stays visible on the data registers.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last = '0, out_last = '0;

    function automatic logic exp_so();
        return (out_q.size() != 0) && net_ro && (out_q[0][63] == net_polarity);
    endfunction

    function automatic logic [63:0] exp_dout();
        if (!nicEn || nicWrEn) return 64'h0;
        case (addr)
            2'd0: return in_last;
            2'd1: return (in_q.size() != 0) ? 64'h1 : 64'h0;
            2'd2: return out_last;
            default: return (out_q.size() != 0) ? 64'h1 : 64'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q.delete(); out_q.delete();
            in_last = '0; out_last = '0;
        end else begin
            logic so, rd, wr, rx;
            so = exp_so();
            rd = nicEn && !nicWrEn && addr == 2'd0 && in_q.size() != 0;
            rx = net_si && in_q.size() == 0;
            wr = nicEn && nicWrEn && addr == 2'd2 && out_q.size() == 0;
            if (so) void'(out_q.pop_front());
            if (wr) begin out_q.push_back(d_in); out_last = d_in; end
            if (rd) void'(in_q.pop_front());
            if (rx) begin in_q.push_back(net_di); in_last = net_di; end
        end
    end

    always @(negedge clk) begin
        chk("net_ri", {63'h0, net_ri}, {63'h0, in_q.size() == 0});
        chk("net_so", {63'h0, net_so}, {63'h0, exp_so()});
        chk("net_do", net_do, out_last);
        chk("d_out", d_out, exp_dout());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn = 0; nicWrEn = 0; net_si = 0; addr = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1; nicWrEn = 0; addr = a;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v);
        nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
    endtask

    initial begin
        repeat (2) step();
        reset = 0;
        step();

        // Idle after reset
        rd(2'd1); #1;
        chk("rst_in_stat", d_out, 64'h0);
        chk("rst_ri", {63'h0, net_ri}, 64'h1);
        rd(2'd3); #1;
        chk("rst_out_stat", d_out, 64'h0);
        chk("rst_so", {63'h0, net_so}, 64'h0);
        step();

        // Matching-polarity send
        net_ro = 1; net_polarity = 0;
        wr(2'd2, 64'h0000_0000_0000_00A5);
        step();
        rd(2'd3); #1;
        chk("a5_out_stat", d_out, 64'h1);
        chk("a5_so", {63'h0, net_so}, 64'h1);
        chk("a5_do", net_do, 64'hA5);
        step();
        chk("a5_out_stat_clr", d_out, 64'h0);

        // Polarity mismatch and backpressure, plus write-while-full
        wr(2'd2, 64'h8000_0000_0000_0001);
        step();
        idle(); #1;
        chk("pol_held", {63'h0, net_so}, 64'h0);
        wr(2'd2, 64'h0000_0000_0000_DEAD);
        step();
        net_ro = 0; net_polarity = 1; idle(); #1;
        chk("bp_held", {63'h0, net_so}, 64'h0);
        step();
        net_ro = 1; wr(2'd2, 64'h0000_0000_0000_BEEF); #1;
        chk("pol_send", {63'h0, net_so}, 64'h1);
        chk("pol_do", net_do, 64'h8000_0000_0000_0001);
        step();
        rd(2'd3); #1;
        chk("pol_out_stat", d_out, 64'h0);
        chk("pol_do_after", net_do, 64'h8000_0000_0000_0001);
        step();

        // Receive, drop while full, read-clear
        idle(); net_si = 1; net_di = 64'h1234;
        step();
        net_di = 64'h5A5A; rd(2'd1); #1;
        chk("rx_ri", {63'h0, net_ri}, 64'h0);
        chk("rx_in_stat", d_out, 64'h1);
        step();
        net_si = 0; rd(2'd0); #1;
        chk("rx_data", d_out, 64'h1234);
        step();
        idle(); #1;
        chk("rx_ri_after", {63'h0, net_ri}, 64'h1);
        step();

        // Reset with both buffers full
        net_ro = 0; net_polarity = 0;
        wr(2'd2, 64'h0000_0000_0000_0042);
        net_si = 1; net_di = 64'h5555;
        step();
        idle(); net_ro = 1; #1;
        chk("pre_rst_so", {63'h0, net_so}, 64'h1);
        chk("pre_rst_ri", {63'h0, net_ri}, 64'h0);
        reset = 1; #1;
        chk("async_rst_so", {63'h0, net_so}, 64'h0);
        chk("async_rst_ri", {63'h0, net_ri}, 64'h1);
        chk("async_rst_do", net_do, 64'h0);
        step();
        step();
        reset = 0;
        repeat (3) begin
            step();
            chk("post_rst_so", {63'h0, net_so}, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
